// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word fetches to the instruction SRAM, buffers
// returned words in a small circular FIFO and presents them to decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 4,
    parameter int          CNT_W      = $clog2(IBUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_sram_req,
    output logic [31:0]      inst_sram_addr,
    input  logic             inst_sram_addr_ok,
    input  logic             inst_sram_data_ok,
    input  logic [31:0]      inst_sram_rdata,
    input  logic             br_redirect,
    input  logic [31:0]      br_target,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    input  logic             id_ready,
    output logic [CNT_W-1:0] ibuf_count
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);

    typedef enum logic {
        S_RESET,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard_cnt;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       pc_mem   [IBUF_DEPTH];
    logic [31:0]       inst_mem [IBUF_DEPTH];

    logic              accept;
    logic              resp;
    logic              keep;
    logic              pop;
    logic [CNT_W:0]    in_flight;
    logic [CNT_W-1:0]  outstanding_next;
    logic [31:0]       target_aligned;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_RESET;
        else         state <= state_next;
    end

    // Every slot is reserved at request time (in flight or buffered), so a
    // returning word always finds room in the FIFO.
    always_comb begin
        state_next    = state;
        inst_sram_req = 1'b0;
        in_flight     = {1'b0, outstanding} + {1'b0, count_q};
        case (state)
            S_RESET: state_next = S_RUN;
            S_RUN: begin
                state_next    = S_RUN;
                inst_sram_req = (in_flight < (CNT_W+1)'(IBUF_DEPTH));
            end
            default: state_next = S_RESET;
        endcase
    end

    assign inst_sram_addr   = fetch_pc;
    assign accept           = inst_sram_req & inst_sram_addr_ok;
    assign resp             = inst_sram_data_ok & (outstanding != '0);
    assign keep             = resp & (discard_cnt == '0) & ~br_redirect;
    assign pop              = id_valid & id_ready;
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(resp);
    assign target_aligned   = br_target & 32'hffff_fffc;

    assign id_valid   = (count_q != '0);
    assign id_pc      = pc_mem[rd_ptr];
    assign id_inst    = inst_mem[rd_ptr];
    assign ibuf_count = count_q;

    // A redirect marks every response still in flight, including one accepted
    // on the same edge, as stale.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            count_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (br_redirect) begin
                fetch_pc    <= target_aligned;
                resp_pc     <= target_aligned;
                discard_cnt <= outstanding_next;
                count_q     <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CNT_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count_q <= count_q + CNT_W'(keep) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: table-driven fill/backpressure run
// plus hand-written stall, redirect and mid-stream reset sequences.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;
    logic [2:0]  ibuf_count;

    logic        mem_auto = 1'b0;
    logic        mem_give = 1'b0;
    logic [31:0] mq [16];
    logic [3:0]  m_wr;
    logic [3:0]  m_rd;
    logic [4:0]  m_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        id_ready;
        logic        addr_ok;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [2:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [11];

    inst_fetch_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_redirect       (br_redirect),
        .br_target         (br_target),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_inst           (id_inst),
        .id_ready          (id_ready),
        .ibuf_count        (ibuf_count)
    );

    always #5 clk = ~clk;

    // Memory model: returns rdata = address, in order, one cycle after acceptance
    // at the earliest; mem_give releases responses one per cycle on demand.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_wr  <= 4'd0;
            m_rd  <= 4'd0;
            m_cnt <= 5'd0;
        end else begin
            if (inst_sram_req && inst_sram_addr_ok) begin
                mq[m_wr] <= inst_sram_addr;
                m_wr     <= m_wr + 4'd1;
            end
            if (inst_sram_data_ok) m_rd <= m_rd + 4'd1;
            m_cnt <= m_cnt + 5'(inst_sram_req && inst_sram_addr_ok) - 5'(inst_sram_data_ok);
        end
    end

    assign inst_sram_data_ok = resetn && (mem_auto || mem_give) && (m_cnt != 5'd0);
    assign inst_sram_rdata   = mq[m_rd];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        resetn            = 1'b0;
        br_redirect       = 1'b0;
        br_target         = 32'h0;
        id_ready          = 1'b0;
        inst_sram_addr_ok = 1'b0;
        mem_auto          = 1'b0;
        mem_give          = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset req", 32'(inst_sram_req), 32'd0);
        checkOutput("reset valid", 32'(id_valid), 32'd0);
        checkOutput("reset count", 32'(ibuf_count), 32'd0);
        checkOutput("reset addr", inst_sram_addr, 32'h1c000000);
        resetn = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        id_ready          = v.id_ready;
        inst_sram_addr_ok = v.addr_ok;
        #1;
        checkOutput($sformatf("row%0d req", idx), 32'(inst_sram_req), 32'(v.exp_req));
        checkOutput($sformatf("row%0d addr", idx), inst_sram_addr, v.exp_addr);
        checkOutput($sformatf("row%0d count", idx), 32'(ibuf_count), 32'(v.exp_count));
        checkOutput($sformatf("row%0d valid", idx), 32'(id_valid), 32'(v.exp_valid));
        if (v.exp_valid) checkOutput($sformatf("row%0d pc", idx), id_pc, v.exp_pc);
    endtask

    task automatic waitValid(input string name, output int waited);
        waited = 0;
        while (!id_valid && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput({name, " valid within bound"}, 32'(id_valid), 32'd1);
    endtask

    initial begin
        int waited;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h1c000000, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h1c000004, 3'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h1c000008, 3'd1, 1'b1, 32'h1c000000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h1c00000c, 3'd2, 1'b1, 32'h1c000000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h1c000010, 3'd3, 1'b1, 32'h1c000000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h1c000010, 3'd4, 1'b1, 32'h1c000000};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h1c000010, 3'd4, 1'b1, 32'h1c000000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h1c000010, 3'd3, 1'b1, 32'h1c000004};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h1c000014, 3'd3, 1'b1, 32'h1c000004};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h1c000014, 3'd4, 1'b1, 32'h1c000004};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h1c000014, 3'd4, 1'b1, 32'h1c000004};

        // Streaming fetch with decode always ready: no bubbles after fill
        doReset();
        inst_sram_addr_ok = 1'b1;
        id_ready          = 1'b1;
        mem_auto          = 1'b1;
        @(negedge clk);
        #1;
        waitValid("stream", waited);
        checkOutput("stream fill latency", 32'(waited), 32'd2);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stream%0d valid", k), 32'(id_valid), 32'd1);
            checkOutput($sformatf("stream%0d pc", k), id_pc, 32'h1c000000 + 32'(4 * k));
            checkOutput($sformatf("stream%0d inst", k), id_inst, 32'h1c000000 + 32'(4 * k));
            @(negedge clk);
            #1;
        end

        // Backpressure: buffer fills, requests stop, one pop frees one request
        doReset();
        mem_auto = 1'b1;
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // addr_ok held low: request and address stay stable
        doReset();
        id_ready = 1'b1;
        mem_auto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inst_sram_addr_ok = 1'b0;
            #1;
            checkOutput($sformatf("stall%0d req", k), 32'(inst_sram_req), 32'd1);
            checkOutput($sformatf("stall%0d addr", k), inst_sram_addr, 32'h1c000000);
        end
        @(negedge clk);
        inst_sram_addr_ok = 1'b1;
        #1;
        checkOutput("stall accept-cycle addr", inst_sram_addr, 32'h1c000000);
        @(negedge clk);
        #1;
        checkOutput("stall after accept addr", inst_sram_addr, 32'h1c000004);

        // Redirect with 2 outstanding and 2 buffered
        doReset();
        inst_sram_addr_ok = 1'b1;
        @(negedge clk);
        #1;
        waited = 0;
        while (inst_sram_req && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("redir fill req stops", 32'(inst_sram_req), 32'd0);
        mem_give = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_give = 1'b0;
        #1;
        checkOutput("redir pre count", 32'(ibuf_count), 32'd2);
        br_redirect       = 1'b1;
        br_target         = 32'h1c000100;
        inst_sram_addr_ok = 1'b0;
        @(negedge clk);
        br_redirect = 1'b0;
        #1;
        checkOutput("redir flush count", 32'(ibuf_count), 32'd0);
        checkOutput("redir flush valid", 32'(id_valid), 32'd0);
        checkOutput("redir new addr", inst_sram_addr, 32'h1c000100);
        checkOutput("redir new req", 32'(inst_sram_req), 32'd1);
        mem_give = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("redir drop%0d count", k), 32'(ibuf_count), 32'd0);
            checkOutput($sformatf("redir drop%0d valid", k), 32'(id_valid), 32'd0);
        end
        mem_give          = 1'b0;
        mem_auto          = 1'b1;
        inst_sram_addr_ok = 1'b1;
        waitValid("redir refill", waited);
        checkOutput("redir first pc", id_pc, 32'h1c000100);
        checkOutput("redir first inst", id_inst, 32'h1c000100);

        // Redirect coinciding with an acceptance and a data_ok
        doReset();
        inst_sram_addr_ok = 1'b1;
        mem_auto          = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("coin first addr", inst_sram_addr, 32'h1c000000);
        @(negedge clk);
        br_redirect = 1'b1;
        br_target   = 32'h1c000203;
        #1;
        checkOutput("coin pre addr", inst_sram_addr, 32'h1c000004);
        @(negedge clk);
        br_redirect = 1'b0;
        #1;
        checkOutput("coin count", 32'(ibuf_count), 32'd0);
        checkOutput("coin valid", 32'(id_valid), 32'd0);
        checkOutput("coin addr aligned", inst_sram_addr, 32'h1c000200);
        @(negedge clk);
        #1;
        checkOutput("coin stale dropped count", 32'(ibuf_count), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("coin new valid", 32'(id_valid), 32'd1);
        checkOutput("coin new pc", id_pc, 32'h1c000200);
        checkOutput("coin new inst", id_inst, 32'h1c000200);
        checkOutput("coin new count", 32'(ibuf_count), 32'd1);

        // Asynchronous reset in the middle of a stream
        doReset();
        inst_sram_addr_ok = 1'b1;
        id_ready          = 1'b1;
        mem_auto          = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        checkOutput("midrst pre valid", 32'(id_valid), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("midrst req", 32'(inst_sram_req), 32'd0);
        checkOutput("midrst valid", 32'(id_valid), 32'd0);
        checkOutput("midrst count", 32'(ibuf_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst restart req", 32'(inst_sram_req), 32'd1);
        checkOutput("midrst restart addr", inst_sram_addr, 32'h1c000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
